// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, one-outstanding req/gnt/rvalid fetch, skid buffer and IF/ID register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_ip,
  input  logic        branch_taken_ip,
  input  logic [31:0] branch_target_ip,
  output logic        instr_mem_req_op,
  output logic [31:0] instr_mem_addr_op,
  input  logic        instr_mem_gnt_ip,
  input  logic        instr_mem_rvalid_ip,
  input  logic [31:0] instr_mem_rdata_ip,
  output logic        ID_valid_op,
  output logic [31:0] ID_instr_op,
  output logic [31:0] ID_pc_op,
  output logic [6:0]  ID_instr_opcode_op,
  output logic [4:0]  ID_src1_addr_op,
  output logic [4:0]  ID_src2_addr_op,
  output logic [31:0] stall_cycles_op,
  output logic [31:0] flush_count_op
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DROP, S_FULL} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc;
  logic        r_id_valid;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;

  logic        w_req;
  logic        w_fire;
  logic        w_pending;
  logic [31:0] w_target;

  assign w_target = branch_target_ip & ~32'h3;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_req = 1'b0;
    case (r_state)
      S_FETCH: w_req = 1'b1;
      S_WAIT:  w_req = instr_mem_rvalid_ip && !stall_ip;
      S_DROP:  w_req = instr_mem_rvalid_ip;
      default: w_req = 1'b0;
    endcase
    w_req = w_req && reset;
  end

  assign w_fire    = w_req && instr_mem_gnt_ip;
  // A request is still in flight after this cycle if one was just granted or the pending one did not return.
  assign w_pending = w_fire ||
                     (((r_state == S_WAIT) || (r_state == S_DROP)) && !instr_mem_rvalid_ip);

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_buf_instr <= '0;
      r_buf_pc    <= '0;
      r_id_valid  <= 1'b0;
      r_id_instr  <= '0;
      r_id_pc     <= '0;
    end else if (branch_taken_ip) begin
      // Leaving FULL is what empties the skid buffer; its state is its valid bit.
      r_id_valid <= 1'b0;
      r_pc       <= w_target;
      r_state    <= w_pending ? S_DROP : S_FETCH;
    end else begin
      if (w_fire) r_pc <= r_pc + 32'd4;
      if (!stall_ip) r_id_valid <= 1'b0;
      case (r_state)
        S_FETCH: if (instr_mem_gnt_ip) r_state <= S_WAIT;
        S_WAIT: begin
          if (instr_mem_rvalid_ip) begin
            if (!stall_ip) begin
              r_id_valid <= 1'b1;
              r_id_instr <= instr_mem_rdata_ip;
              r_id_pc    <= r_pc - 32'd4;
              r_state    <= instr_mem_gnt_ip ? S_WAIT : S_FETCH;
            end else begin
              r_buf_instr <= instr_mem_rdata_ip;
              r_buf_pc    <= r_pc - 32'd4;
              r_state     <= S_FULL;
            end
          end
        end
        S_DROP: if (instr_mem_rvalid_ip) r_state <= instr_mem_gnt_ip ? S_WAIT : S_FETCH;
        S_FULL: begin
          if (!stall_ip) begin
            r_id_valid <= 1'b1;
            r_id_instr <= r_buf_instr;
            r_id_pc    <= r_buf_pc;
            r_state    <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign instr_mem_req_op   = w_req;
  assign instr_mem_addr_op  = r_pc;
  assign ID_valid_op        = r_id_valid;
  assign ID_instr_op        = r_id_instr;
  assign ID_pc_op           = r_id_pc;
  assign ID_instr_opcode_op = r_id_instr[6:0];
  assign ID_src1_addr_op    = r_id_instr[19:15];
  assign ID_src2_addr_op    = r_id_instr[24:20];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (stall_ip && r_id_valid && (r_stall_cycles != 32'hFFFF_FFFF))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (branch_taken_ip && (r_flush_count != 32'hFFFF_FFFF))
        r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign stall_cycles_op = r_stall_cycles;
  assign flush_count_op  = r_flush_count;
`else
  assign stall_cycles_op = 32'd0;
  assign flush_count_op  = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus hand-written reset, wrap and counter sequences.
module tb_fetch_stage;

  localparam logic [31:0] W0 = 32'h0050_0093;
  localparam logic [31:0] W1 = 32'h0060_0113;
  localparam logic [31:0] W2 = 32'h0070_0193;
  localparam logic [31:0] W3 = 32'h0080_0213;
  localparam logic [31:0] W4 = 32'h0090_0293;
  localparam logic [31:0] W5 = 32'h00A0_0313;
  localparam logic [31:0] W6 = 32'h00B0_0393;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_ip, branch_taken_ip, gnt, rvalid;
  logic [31:0] branch_target_ip, rdata;
  logic        req, id_valid;
  logic [31:0] addr, id_instr, id_pc, stall_cycles, flush_count;
  logic [6:0]  id_opcode;
  logic [4:0]  id_src1, id_src2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk                 (clk),
    .reset               (reset),
    .stall_ip            (stall_ip),
    .branch_taken_ip     (branch_taken_ip),
    .branch_target_ip    (branch_target_ip),
    .instr_mem_req_op    (req),
    .instr_mem_addr_op   (addr),
    .instr_mem_gnt_ip    (gnt),
    .instr_mem_rvalid_ip (rvalid),
    .instr_mem_rdata_ip  (rdata),
    .ID_valid_op         (id_valid),
    .ID_instr_op         (id_instr),
    .ID_pc_op            (id_pc),
    .ID_instr_opcode_op  (id_opcode),
    .ID_src1_addr_op     (id_src1),
    .ID_src2_addr_op     (id_src2),
    .stall_cycles_op     (stall_cycles),
    .flush_count_op      (flush_count)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] t,
                       input logic g, input logic r, input logic [31:0] d);
    stall_ip = s; branch_taken_ip = b; branch_target_ip = t;
    gnt = g; rvalid = r; rdata = d;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " req"},    {31'd0, req}, 32'd0);
    check({tag, " addr"},   addr, 32'd0);
    check({tag, " valid"},  {31'd0, id_valid}, 32'd0);
    check({tag, " instr"},  id_instr, 32'd0);
    check({tag, " pc"},     id_pc, 32'd0);
    check({tag, " fields"}, {17'd0, id_opcode, id_src1, id_src2}, 32'd0);
    check({tag, " stallc"}, stall_cycles, 32'd0);
    check({tag, " flushc"}, flush_count, 32'd0);
  endtask

  task automatic check_counters(input string tag, input logic [31:0] e_stall, input logic [31:0] e_flush);
`ifdef FETCH_PERF_CNT_EN
    check({tag, " stall_cycles"}, stall_cycles, e_stall);
    check({tag, " flush_count"},  flush_count,  e_flush);
`else
    check({tag, " stall_cycles"}, stall_cycles, 32'd0);
    check({tag, " flush_count"},  flush_count,  32'd0);
    if (e_stall == e_flush) n_checks += 0;
`endif
  endtask

  initial begin
    // stall br tgt gnt rv rdata | req addr vld pc instr
    vq.push_back(vec_t'{0,0,32'h0,  1,0,32'h0, 1,32'h000,0,32'h0,  32'h0}); // c0 first request
    vq.push_back(vec_t'{0,0,32'h0,  1,1,W0,    1,32'h004,0,32'h0,  32'h0}); // c1 back-to-back
    vq.push_back(vec_t'{0,0,32'h0,  1,1,W1,    1,32'h008,1,32'h0,  W0});    // c2 first valid
    vq.push_back(vec_t'{1,0,32'h0,  0,1,W2,    0,32'h00C,1,32'h4,  W1});    // c3 word -> skid
    vq.push_back(vec_t'{1,0,32'h0,  0,0,32'h0, 0,32'h00C,1,32'h4,  W1});    // c4 FULL hold
    vq.push_back(vec_t'{1,0,32'h0,  0,0,32'h0, 0,32'h00C,1,32'h4,  W1});    // c5 FULL hold
    vq.push_back(vec_t'{0,0,32'h0,  0,0,32'h0, 0,32'h00C,1,32'h4,  W1});    // c6 stall falls
    vq.push_back(vec_t'{0,0,32'h0,  1,0,32'h0, 1,32'h00C,1,32'h8,  W2});    // c7 buffered word
    vq.push_back(vec_t'{0,0,32'h0,  0,1,W3,    1,32'h010,0,32'h0,  32'h0}); // c8
    vq.push_back(vec_t'{0,1,32'h103,1,0,32'h0, 1,32'h010,1,32'hC,  W3});    // c9 redirect + gnt
    vq.push_back(vec_t'{0,0,32'h0,  0,0,32'h0, 0,32'h100,0,32'h0,  32'h0}); // c10 DROP wait
    vq.push_back(vec_t'{0,0,32'h0,  1,1,32'hDEADBEEF, 1,32'h100,0,32'h0, 32'h0}); // c11 dropped resp
    vq.push_back(vec_t'{0,0,32'h0,  1,1,W4,    1,32'h104,0,32'h0,  32'h0}); // c12
    vq.push_back(vec_t'{1,0,32'h0,  0,1,W5,    0,32'h108,1,32'h100,W4});    // c13 fill skid
    vq.push_back(vec_t'{1,1,32'h200,0,0,32'h0, 0,32'h108,1,32'h100,W4});    // c14 branch+stall FULL
    for (int i = 0; i < 4; i++)
      vq.push_back(vec_t'{0,0,32'h0,0,0,32'h0, 1,32'h200,0,32'h0,  32'h0}); // c15-18 gnt withheld
    vq.push_back(vec_t'{0,0,32'h0,  1,0,32'h0, 1,32'h200,0,32'h0,  32'h0}); // c19
    vq.push_back(vec_t'{0,0,32'h0,  0,1,W6,    1,32'h204,0,32'h0,  32'h0}); // c20
    vq.push_back(vec_t'{0,0,32'h0,  0,0,32'h0, 1,32'h204,1,32'h200,W6});    // c21
    vq.push_back(vec_t'{0,0,32'h0,  0,0,32'h0, 1,32'h204,0,32'h0,  32'h0}); // c22 bubble

    reset = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    repeat (2) @(negedge clk);
    #1 check_reset_state("reset");
    @(negedge clk);
    reset = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].stall, vq[i].br, vq[i].tgt, vq[i].gnt, vq[i].rv, vq[i].rdata);
      #1;
      check($sformatf("c%0d req", i),   {31'd0, req}, {31'd0, vq[i].e_req});
      check($sformatf("c%0d addr", i),  addr, vq[i].e_addr);
      check($sformatf("c%0d valid", i), {31'd0, id_valid}, {31'd0, vq[i].e_vld});
      if (vq[i].e_vld) begin
        check($sformatf("c%0d pc", i),    id_pc, vq[i].e_pc);
        check($sformatf("c%0d instr", i), id_instr, vq[i].e_instr);
        check($sformatf("c%0d fields", i), {17'd0, id_opcode, id_src1, id_src2},
              {17'd0, vq[i].e_instr[6:0], vq[i].e_instr[19:15], vq[i].e_instr[24:20]});
      end
      @(negedge clk);
    end
    check_counters("table", 32'd5, 32'd2);

    // PC wrap: redirect to 0xFFFF_FFFE (low bits dropped), then the next address wraps to 0.
    drive(0, 1, 32'hFFFF_FFFE, 0, 0, 32'h0);
    @(negedge clk);
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    #1 check("wrap addr", addr, 32'hFFFF_FFFC);
    check("wrap req", {31'd0, req}, 32'd1);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    #1 check("wrap next addr", addr, 32'h0000_0000);
    check("wait no req", {31'd0, req}, 32'd0);

    // Reset asserted while in WAIT with a stray response; everything clears asynchronously.
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 32'h0, 1, 1, 32'hBAD0_BAD0);
    #1 check_reset_state("midreset");
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    #1 check("rel req", {31'd0, req}, 32'd1);
    check("rel addr", addr, 32'h0);
    check("rel valid", {31'd0, id_valid}, 32'd0);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 1, W0);
    #1 check("lat valid N+1", {31'd0, id_valid}, 32'd0);
    @(negedge clk);
    drive(1, 0, 32'h0, 0, 0, 32'h0);
    #1 check("lat valid N+2", {31'd0, id_valid}, 32'd1);
    check("lat pc", id_pc, 32'h0);
    check("lat instr", id_instr, W0);
    check("opcode", {25'd0, id_opcode}, 32'h13);
    check("src1", {27'd0, id_src1}, 32'd0);
    check("src2", {27'd0, id_src2}, 32'd5);
    check("fetch addr", addr, 32'h4);
    @(negedge clk);
    #1 check("stall hold pc", id_pc, 32'h0);
    @(negedge clk);
    drive(0, 1, 32'h40, 0, 0, 32'h0);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    #1 check("redir valid", {31'd0, id_valid}, 32'd0);
    check("redir addr", addr, 32'h40);
    check_counters("perf", 32'd2, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
